divider_32b_seq: RTL and testbench
==================================

Name: divider_32b_seq

Overview:
- Iterative radix-2 restoring divider: the inverse operation of the registered 32b multiplier in the arithmetic module set.
- Accepts a dividend/divisor pair through a valid/ready handshake and computes one quotient bit per cycle.
- Returns quotient and remainder with a one-cycle done pulse.
- Used wherever a product must be undone (normalisation, ratio datapaths); trades area for a 32-cycle latency.

Parameters:
- WIDTH, 32, operand/quotient/remainder width; all widths, counts and latencies below scale with WIDTH (values given for 32).

Ports:
- iClk  input  1  clock; all state changes on rising edge.
- iRst  input  1  asynchronous, active-high reset.
- iEn  input  1  global enable; 0 freezes all state (stall).
- iClr  input  1  synchronous clear; aborts any operation.
- iValid  input  1  request valid.
- oReady  output  1  block can accept a request.
- iData0  input  WIDTH  dividend.
- iData1  input  WIDTH  divisor.
- oValid  output  1  result valid; one-cycle pulse.
- oData  output  WIDTH  quotient.
- oRem  output  WIDTH  remainder.
- oDivZero  output  1  divisor was zero; qualified by oValid.

Behaviour:
- Reset: one clock, iClk; iRst is asynchronous, active-high. On assert, state=IDLE, oReady=1, oValid=0, oData=0, oRem=0, oDivZero=0, counter=0. Reset mid-operation discards the operation.
- iClr (sampled at edge, takes priority over iEn and iValid): same effect as reset, applied synchronously.
- iEn=0 with iClr=0: nothing changes, oValid holds its value, and no handshake occurs.
- FSM states: IDLE, CALC, DONE.
  - IDLE: oReady=1. iValid & iEn at an edge is an accept: latch the dividend into the quotient shift register, latch the divisor, clear the partial remainder, set counter=0. Go to CALC; if the divisor is 0, go straight to DONE.
  - CALC: oReady=0. Each enabled edge performs one step:
    - Shift {rem, quo} left by 1.
    - Trial-subtract the divisor from rem, using a WIDTH+1-bit difference.
    - If the difference is non-negative, rem=diff and quo[0]=1; otherwise quo[0]=0.
    - counter++.
    - After the step with counter==WIDTH-1, go to DONE.
  - DONE: oValid=1 for exactly one enabled cycle and oReady=0. The next enabled edge returns to IDLE. iValid in DONE is ignored.
- Latency: accept edge at cycle T gives oValid=1 in cycle T+WIDTH+1 (T+33 for WIDTH=32) when iEn is held high. With divisor 0, oValid=1 in cycle T+1.
- Outputs are registered. oData, oRem and oDivZero are written on the edge that enters DONE and hold until the next result or clear.
- Divide by zero: oData=all ones, oRem=dividend, oDivZero=1.
- Back-to-back throughput: one result per WIDTH+2 cycles.
- Inputs are captured at accept; they may change afterwards without effect.

Optional Feature:
- Macro: DIVIDER_32B_SEQ_SIGNED_EN.
- When defined, operands are two's complement:
  - Magnitudes are taken at accept; operand signs are registered.
  - Quotient sign = sign0 XOR sign1; result truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Sign fixup is applied on the edge entering DONE, so latency is unchanged.
  - Overflow case 0x80000000 / 0xFFFFFFFF gives oData=0x80000000, oRem=0.
  - Divide by zero gives oData=all ones (-1), oRem=dividend.
- When undefined: unsigned only; no sign logic is synthesised.

Test Plan:
- Reset, then 100 / 7 with iEn=1 -> oValid exactly 33 cycles after accept; oData=14, oRem=2, oDivZero=0; oReady low from accept until the cycle after DONE.
- 0xFFFFFFFF / 1, then 5 / 0xFFFFFFFF -> first gives oData=0xFFFFFFFF, oRem=0. Second gives oData=0, oRem=5.
- 1234 / 0 -> oValid 1 cycle after accept; oData=0xFFFFFFFF, oRem=1234, oDivZero=1.
- 1000 / 3 with iEn deasserted 5 cycles mid-CALC -> oValid at cycle 38 after accept; oData=333, oRem=1. iValid pulses while busy are not accepted.
- iClr asserted at CALC step 10, then immediately new request 9 / 4 -> first operation is discarded and no oValid is produced for it. Outputs are zero after the clear; second result is oData=2, oRem=1. Repeat with async iRst mid-CALC: outputs are zero immediately, before the next edge.
- 200 random pairs compared against a reference model of dividend/divisor and dividend%divisor (plus signed cases -7 / 2 -> -3 rem -1, and 0x80000000 / -1, when DIVIDER_32B_SEQ_SIGNED_EN is defined) -> zero mismatches.

Source files
------------

// File: rtl/divider_32b_seq.sv
// Iterative radix-2 restoring divider: one quotient bit per enabled cycle, registered results.
// Define DIVIDER_32B_SEQ_SIGNED_EN for two's-complement operands; default build is unsigned only.
module divider_32b_seq #(
  parameter int WIDTH = 32
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iEn,
  input  logic             iClr,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iData0,
  input  logic [WIDTH-1:0] iData1,
  output logic             oValid,
  output logic [WIDTH-1:0] oData,
  output logic [WIDTH-1:0] oRem,
  output logic             oDivZero,
  output logic [1:0]       oDbgState
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] res_quo_q, res_quo_d;
  logic [WIDTH-1:0] res_rem_q, res_rem_d;
  logic             div_zero_q, div_zero_d;
  logic             valid_q, valid_d;

  logic [WIDTH:0]   rem_sh, diff;
  logic [WIDTH-1:0] step_quo, step_rem;
  logic [WIDTH-1:0] fix_quo, fix_rem;
  logic [WIDTH-1:0] mag0, mag1;
  logic             last_step;

`ifdef DIVIDER_32B_SEQ_SIGNED_EN
  logic sign0_q, sign0_d;
  logic sign1_q, sign1_d;

  // Divide magnitudes, then restore signs on the edge that enters DONE.
  always_comb begin
    mag0    = iData0[WIDTH-1] ? ({WIDTH{1'b0}} - iData0) : iData0;
    mag1    = iData1[WIDTH-1] ? ({WIDTH{1'b0}} - iData1) : iData1;
    fix_quo = (sign0_q ^ sign1_q) ? ({WIDTH{1'b0}} - step_quo) : step_quo;
    fix_rem = sign0_q ? ({WIDTH{1'b0}} - step_rem) : step_rem;
  end
`else
  always_comb begin
    mag0    = iData0;
    mag1    = iData1;
    fix_quo = step_quo;
    fix_rem = step_rem;
  end
`endif

  // The partial remainder is always below the divisor, so the shifted value fits in WIDTH+1 bits
  // and the top bit of the difference is a clean borrow flag.
  always_comb begin
    rem_sh    = {rem_q, quo_q[WIDTH-1]};
    diff      = rem_sh - {1'b0, dvsr_q};
    step_quo  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    step_rem  = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    last_step = (cnt_q == CW'(WIDTH - 1));
  end

  // Handshake: a request transfers on a rising edge where iValid & oReady & iEn & !iClr;
  // oReady is high only in IDLE, and oValid is a single enabled-cycle pulse in DONE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dvsr_d     = dvsr_q;
    res_quo_d  = res_quo_q;
    res_rem_d  = res_rem_q;
    div_zero_d = div_zero_q;
    valid_d    = valid_q;
`ifdef DIVIDER_32B_SEQ_SIGNED_EN
    sign0_d    = sign0_q;
    sign1_d    = sign1_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (iValid) begin
          quo_d  = mag0;
          dvsr_d = mag1;
          rem_d  = '0;
          cnt_d  = '0;
`ifdef DIVIDER_32B_SEQ_SIGNED_EN
          sign0_d = iData0[WIDTH-1];
          sign1_d = iData1[WIDTH-1];
`endif
          if (iData1 == '0) begin
            state_d    = S_DONE;
            valid_d    = 1'b1;
            res_quo_d  = '1;
            res_rem_d  = iData0;
            div_zero_d = 1'b1;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        quo_d = step_quo;
        rem_d = step_rem;
        cnt_d = cnt_q + 1'b1;
        if (last_step) begin
          state_d    = S_DONE;
          valid_d    = 1'b1;
          res_quo_d  = fix_quo;
          res_rem_d  = fix_rem;
          div_zero_d = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvsr_q     <= '0;
      res_quo_q  <= '0;
      res_rem_q  <= '0;
      div_zero_q <= 1'b0;
      valid_q    <= 1'b0;
    end else if (iClr) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvsr_q     <= '0;
      res_quo_q  <= '0;
      res_rem_q  <= '0;
      div_zero_q <= 1'b0;
      valid_q    <= 1'b0;
    end else if (iEn) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dvsr_q     <= dvsr_d;
      res_quo_q  <= res_quo_d;
      res_rem_q  <= res_rem_d;
      div_zero_q <= div_zero_d;
      valid_q    <= valid_d;
    end
  end

`ifdef DIVIDER_32B_SEQ_SIGNED_EN
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      sign0_q <= 1'b0;
      sign1_q <= 1'b0;
    end else if (iClr) begin
      sign0_q <= 1'b0;
      sign1_q <= 1'b0;
    end else if (iEn) begin
      sign0_q <= sign0_d;
      sign1_q <= sign1_d;
    end
  end
`endif

  assign oReady    = (state_q == S_IDLE);
  assign oValid    = valid_q;
  assign oData     = res_quo_q;
  assign oRem      = res_rem_q;
  assign oDivZero  = div_zero_q;
  assign oDbgState = state_q;

endmodule

// File: tb/tb_divider_32b_seq.sv
// Scoreboard bench for divider_32b_seq: driver pushes expected results at accept, monitor pops on oValid.
module tb_divider_32b_seq;

  localparam int W = 32;

  logic         iClk = 1'b0;
  logic         iRst = 1'b1;
  logic         iEn = 1'b1;
  logic         iClr = 1'b0;
  logic         iValid = 1'b0;
  logic [W-1:0] iData0 = '0;
  logic [W-1:0] iData1 = '0;
  logic         oReady;
  logic         oValid;
  logic [W-1:0] oData;
  logic [W-1:0] oRem;
  logic         oDivZero;
  logic [1:0]   oDbgState;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic prev_v = 1'b0;

  logic [W-1:0] exp_quo_q[$];
  logic [W-1:0] exp_rem_q[$];
  logic         exp_dz_q[$];
  int           exp_lat_q[$];
  int           acc_cyc_q[$];

  divider_32b_seq #(.WIDTH(W)) dut (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iClr(iClr), .iValid(iValid),
    .oReady(oReady), .iData0(iData0), .iData1(iData1), .oValid(oValid),
    .oData(oData), .oRem(oRem), .oDivZero(oDivZero), .oDbgState(oDbgState)
  );

  // clock / reset
  always #5 iClk = ~iClk;
  always @(posedge iClk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // reference model: plain arithmetic on the operand values
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz);
    logic [W-1:0] min_neg;
    min_neg = {1'b1, {(W-1){1'b0}}};
    dz = 1'b0;
    if (b == '0) begin
      q = '1; r = a; dz = 1'b1;
    end else begin
`ifdef DIVIDER_32B_SEQ_SIGNED_EN
      if (a == min_neg && b == '1) begin
        q = min_neg; r = '0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
`else
      q = a / b;
      r = a % b;
      if (min_neg == '0) r = '0;
`endif
    end
  endfunction

  function automatic void drop_last();
    void'(exp_quo_q.pop_back());
    void'(exp_rem_q.pop_back());
    void'(exp_dz_q.pop_back());
    void'(exp_lat_q.pop_back());
    void'(acc_cyc_q.pop_back());
  endfunction

  // driver: called at a negedge; returns at the negedge after the accept edge
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input int stall);
    logic [W-1:0] q, r;
    logic dz;
    iData0 = a;
    iData1 = b;
    iValid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (oReady && iEn && !iClr) begin
        model(a, b, q, r, dz);
        exp_quo_q.push_back(q);
        exp_rem_q.push_back(r);
        exp_dz_q.push_back(dz);
        exp_lat_q.push_back((b == '0) ? 1 : W + 1 + stall);
        acc_cyc_q.push_back(cyc + 1);
        @(posedge iClk);
        @(negedge iClk);
        iValid = 1'b0;
        iData0 = $urandom;
        iData1 = $urandom;
        return;
      end
      @(negedge iClk);
    end
    check("accept_timeout", 64'd0, 64'd1);
    iValid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && exp_quo_q.size() != 0; i++) @(negedge iClk);
    if (exp_quo_q.size() != 0) begin
      check("result_timeout", 64'(exp_quo_q.size()), 64'd0);
      exp_quo_q.delete(); exp_rem_q.delete(); exp_dz_q.delete();
      exp_lat_q.delete(); acc_cyc_q.delete();
    end
    @(negedge iClk);
  endtask

  // monitor / scoreboard
  always @(negedge iClk) begin
    if (!iRst && oValid && !prev_v) begin
      if (exp_quo_q.size() == 0) begin
        check("unexpected_valid", 64'd1, 64'd0);
      end else begin
        check("quotient", 64'(oData), 64'(exp_quo_q.pop_front()));
        check("remainder", 64'(oRem), 64'(exp_rem_q.pop_front()));
        check("div_zero", 64'(oDivZero), 64'(exp_dz_q.pop_front()));
        check("latency", 64'(cyc - acc_cyc_q.pop_front() + 1), 64'(exp_lat_q.pop_front()));
      end
    end
    prev_v = oValid && !iRst;
  end

  initial begin
    logic bad_ready;
    logic [W-1:0] a, b;
    #12;
    check("rst_ready", 64'(oReady), 64'd1);
    check("rst_valid", 64'(oValid), 64'd0);
    check("rst_outputs", {31'd0, oDivZero, oData}, 64'd0);
    check("rst_rem", 64'(oRem), 64'd0);
    check("rst_state", 64'(oDbgState), 64'd0);
    @(negedge iClk);
    iRst = 1'b0;
    @(negedge iClk);

    // 100 / 7 with ready tracking
    send(100, 7, 0);
    bad_ready = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      if (oReady) bad_ready = 1'b1;
      if (k < 33) @(negedge iClk);
    end
    check("ready_low_busy", 64'(bad_ready), 64'd0);
    @(negedge iClk);
    check("ready_after_done", 64'(oReady), 64'd1);
    wait_done();

    send(32'hFFFF_FFFF, 1, 0);
    wait_done();
    send(5, 32'hFFFF_FFFF, 0);
    wait_done();
    send(1234, 0, 0);
    wait_done();

    // stall mid-calc while busy requests are presented
    send(1000, 3, 0);
    repeat (10) @(negedge iClk);
    iEn = 1'b0;
    iValid = 1'b1;
    iData0 = 77;
    iData1 = 5;
    repeat (5) @(negedge iClk);
    iEn = 1'b1;
    repeat (3) @(negedge iClk);
    iValid = 1'b0;
    exp_lat_q[0] = W + 1 + 5;
    wait_done();

    // synchronous clear at step 10
    send(32'd123456, 7, 0);
    repeat (10) @(negedge iClk);
    iClr = 1'b1;
    @(negedge iClk);
    iClr = 1'b0;
    drop_last();
    check("clr_outputs", {31'd0, oDivZero, oData}, 64'd0);
    check("clr_rem", 64'(oRem), 64'd0);
    check("clr_ready", 64'(oReady), 64'd1);
    send(9, 4, 0);
    wait_done();

    // asynchronous reset mid-calc
    send(50000, 13, 0);
    repeat (10) @(negedge iClk);
    #2 iRst = 1'b1;
    #1;
    drop_last();
    check("arst_outputs", {31'd0, oDivZero, oData}, 64'd0);
    check("arst_rem", 64'(oRem), 64'd0);
    check("arst_ready_valid", {62'd0, oReady, oValid}, 64'd2);
    @(negedge iClk);
    iRst = 1'b0;
    @(negedge iClk);

`ifdef DIVIDER_32B_SEQ_SIGNED_EN
    send(-32'sd7, 2, 0);
    send(32'h8000_0000, 32'hFFFF_FFFF, 0);
    send(-32'sd100, -32'sd7, 0);
    wait_done();
`endif

    // randomized back-to-back traffic
    for (int n = 0; n < 200; n++) begin
      a = $urandom;
      case ($urandom_range(0, 9))
        0: b = '0;
        1, 2, 3: b = $urandom_range(1, 15);
        4: b = $urandom;
        5: b = a;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      send(a, b, 0);
    end
    wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
